// File: rtl/mac_stats_pkg.sv
// Shared definitions for the MAC statistics / config register bank.
// Holds the CTRL register bit positions, the address region-select bit,
// the status (sticky overflow) register index and the region enum.
package mac_stats_pkg;

    localparam int unsigned CTRL_SAT        = 0;
    localparam int unsigned CTRL_COR        = 1;
    localparam int unsigned CTRL_FREEZE     = 2;
    localparam int unsigned CTRL_SNAP       = 3;
    localparam int unsigned CTRL_IRQ_EN_LSB = 8;
    localparam int unsigned IRQ_EN_COUNT    = 8;

    localparam int unsigned REGION_BIT = 5;
    localparam logic [4:0]  STATUS_IDX = 5'd31;

    typedef enum logic {
        REGION_CFG = 1'b0,
        REGION_CNT = 1'b1
    } reg_region_e;

endpackage

// File: rtl/mac_stat_counter.sv
// One statistics counter with snapshot shadow.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   inc, amt    increment enable and amount
//   sat         1 = clamp at all-ones on carry, 0 = wrap
//   freeze      ignore inc
//   clr         clear-on-read: clears cnt and shadow (a same-cycle event still lands)
//   snap        copy current cnt into shadow
//   cnt, shadow live and snapshot values
//   ovf_pulse   carry out of this cycle's increment
module mac_stat_counter #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned INC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic [INC_W-1:0] amt,
    input  logic             sat,
    input  logic             freeze,
    input  logic             clr,
    input  logic             snap,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] shadow,
    output logic             ovf_pulse
);

    localparam int unsigned SUM_W = CNT_W + 1;

    logic             active;
    logic [CNT_W:0]   sum;

    always_comb begin
        active    = inc && !freeze;
        sum       = {1'b0, cnt} + SUM_W'(amt);
        // A clear-on-read restarts from zero, so the increment cannot carry.
        ovf_pulse = active && !clr && sum[CNT_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= active ? CNT_W'(amt) : '0;
        end else if (active) begin
            if (sum[CNT_W] && sat) begin
                cnt <= '1;
            end else begin
                cnt <= sum[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (clr) begin
            shadow <= '0;
        end else if (snap) begin
            shadow <= cnt;
        end
    end

endmodule

// File: rtl/mac_stat_bank.sv
// Config register file plus statistics counter bank for the Ethernet MAC.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   reg_addr              bit5=0 config region, bit5=1 counter region; index in [4:0]
//   reg_wdata, reg_write  host write data / one-cycle write strobe
//   reg_read              one-cycle read strobe
//   reg_rdata, reg_rvalid read data, valid one cycle after reg_read
//   evt_inc, evt_amt      per-counter increment enable / amount (INC_W per counter)
//   cfg_out               all config registers, 16 bits each, flattened
//   irq                   level interrupt on enabled sticky overflows
module mac_stat_bank
    import mac_stats_pkg::*;
#(
    parameter int unsigned NUM_CFG = 16,
    parameter int unsigned NUM_CNT = 8,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned INC_W   = 16,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [5:0]               reg_addr,
    input  logic [DATA_W-1:0]        reg_wdata,
    input  logic                     reg_write,
    input  logic                     reg_read,
    output logic [DATA_W-1:0]        reg_rdata,
    output logic                     reg_rvalid,
    input  logic [NUM_CNT-1:0]       evt_inc,
    input  logic [NUM_CNT*INC_W-1:0] evt_amt,
    output logic [NUM_CFG*16-1:0]    cfg_out,
    output logic                     irq
);

    reg_region_e        region;
    logic [4:0]         idx;
    logic               cfg_wr;
    logic               cnt_rd;
    logic               status_wr;
    logic               snap;
    logic [15:0]        wdata16;
    logic [15:0]        ctrl_wdata;
    logic [15:0]        ctrl;

    logic [15:0]        cfg_q [NUM_CFG];
    logic [CNT_W-1:0]   cnt_val [NUM_CNT];
    logic [CNT_W-1:0]   shadow_val [NUM_CNT];
    logic [NUM_CNT-1:0] ovf_vec;
    logic [NUM_CNT-1:0] cor_clr;
    logic [NUM_CNT-1:0] ovf_sticky;
    logic [NUM_CNT-1:0] w1c_mask;
    logic [NUM_CNT-1:0] irq_en;
    logic               snap_seen;
    logic [DATA_W-1:0]  rd_val;
    logic               unused_wdata;

    assign unused_wdata = ^reg_wdata;

    // Address decode
    always_comb begin
        region     = reg_region_e'(reg_addr[REGION_BIT]);
        idx        = reg_addr[4:0];
        wdata16    = 16'(reg_wdata);
        ctrl       = cfg_q[0];
        cfg_wr     = reg_write && (region == REGION_CFG);
        cnt_rd     = reg_read && (region == REGION_CNT);
        status_wr  = reg_write && (region == REGION_CNT) && (idx == STATUS_IDX);
        snap       = cfg_wr && (idx == 5'd0) && wdata16[CTRL_SNAP];
        ctrl_wdata = wdata16;
        // SNAP is a command, never stored.
        ctrl_wdata[CTRL_SNAP] = 1'b0;
        w1c_mask   = status_wr ? NUM_CNT'(reg_wdata) : '0;
    end

    always_comb begin
        cor_clr = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            cor_clr[i] = cnt_rd && ctrl[CTRL_COR] && (32'(idx) == i);
        end
    end

    // Config register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CFG; i++) begin
                cfg_q[i] <= '0;
            end
        end else if (cfg_wr) begin
            for (int unsigned i = 0; i < NUM_CFG; i++) begin
                if (32'(idx) == i) begin
                    cfg_q[i] <= (i == 0) ? ctrl_wdata : wdata16;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
        assign cfg_out[g*16 +: 16] = cfg_q[g];
    end

    // Counter bank
    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        mac_stat_counter #(
            .CNT_W (CNT_W),
            .INC_W (INC_W)
        ) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (evt_inc[g]),
            .amt       (evt_amt[g*INC_W +: INC_W]),
            .sat       (ctrl[CTRL_SAT]),
            .freeze    (ctrl[CTRL_FREEZE]),
            .clr       (cor_clr[g]),
            .snap      (snap),
            .cnt       (cnt_val[g]),
            .shadow    (shadow_val[g]),
            .ovf_pulse (ovf_vec[g])
        );
    end

    // Sticky overflow and snapshot history; a same-cycle overflow beats W1C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= '0;
            snap_seen  <= 1'b0;
        end else begin
            ovf_sticky <= (ovf_sticky & ~w1c_mask) | ovf_vec;
            if (snap) begin
                snap_seen <= 1'b1;
            end
        end
    end

    always_comb begin
        irq_en = '0;
        for (int unsigned i = 0; i < NUM_CNT && i < IRQ_EN_COUNT; i++) begin
            irq_en[i] = ctrl[CTRL_IRQ_EN_LSB + i];
        end
    end

    assign irq = |(ovf_sticky & irq_en);

    // Read mux samples pre-update state, so a colliding write is not visible.
    always_comb begin
        rd_val = '0;
        if (region == REGION_CFG) begin
            for (int unsigned i = 0; i < NUM_CFG; i++) begin
                if (32'(idx) == i) begin
                    rd_val = DATA_W'(cfg_q[i]);
                end
            end
        end else if (idx == STATUS_IDX) begin
            rd_val = DATA_W'(ovf_sticky);
        end else begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                if (32'(idx) == i) begin
                    rd_val = snap_seen ? DATA_W'(shadow_val[i]) : DATA_W'(cnt_val[i]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_rdata  <= '0;
            reg_rvalid <= 1'b0;
        end else begin
            reg_rvalid <= reg_read;
            reg_rdata  <= reg_read ? rd_val : '0;
        end
    end

endmodule

// File: tb/tb_mac_stat_bank.sv
module tb_mac_stat_bank;

    localparam int unsigned NCFG = 16;
    localparam int unsigned NCNT = 8;

    logic              clk;
    logic              rst_n;
    logic [5:0]        reg_addr;
    logic [31:0]       reg_wdata;
    logic              reg_write;
    logic              reg_read;
    logic [31:0]       reg_rdata;
    logic              reg_rvalid;
    logic [NCNT-1:0]   evt_inc;
    logic [NCNT*8-1:0] evt_amt;
    logic [NCFG*16-1:0] cfg_out;
    logic              irq;

    mac_stat_bank #(
        .NUM_CFG (NCFG),
        .NUM_CNT (NCNT),
        .CNT_W   (8),
        .INC_W   (8),
        .DATA_W  (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_write  (reg_write),
        .reg_read   (reg_read),
        .reg_rdata  (reg_rdata),
        .reg_rvalid (reg_rvalid),
        .evt_inc    (evt_inc),
        .evt_amt    (evt_amt),
        .cfg_out    (cfg_out),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passes = 0;
    int checks = 0;
    int fails  = 0;

    // Reference model: plain integer state of the register bank
    int unsigned m_cnt    [NCNT];
    int unsigned m_shadow [NCNT];
    logic [15:0] m_cfg    [NCFG];
    logic [7:0]  m_sticky;
    bit          m_snap_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cfg_out();
        logic [NCFG*16-1:0] exp;
        for (int i = 0; i < NCFG; i++) exp[i*16 +: 16] = m_cfg[i];
        checks++;
        assert (cfg_out === exp) passes++;
        else begin
            fails++;
            $error("FAIL cfg_out: observed 0x%0h expected 0x%0h", cfg_out, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCNT; i++) begin
            m_cnt[i]    = 0;
            m_shadow[i] = 0;
        end
        for (int i = 0; i < NCFG; i++) m_cfg[i] = '0;
        m_sticky    = '0;
        m_snap_seen = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [5:0] a);
        int i;
        i = int'(a[4:0]);
        if (!a[5]) return (i < NCFG) ? 32'(m_cfg[i]) : 32'd0;
        if (i == 31) return 32'(m_sticky);
        if (i < NCNT) return m_snap_seen ? m_shadow[i] : m_cnt[i];
        return 32'd0;
    endfunction

    function automatic logic model_irq();
        return |(m_sticky & m_cfg[0][15:8]);
    endfunction

    // Apply one cycle of the currently driven inputs to the model.
    task automatic model_update();
        logic [15:0] ctrl;
        int          i_addr;
        bit          snap;
        bit          active;
        bit          clr;
        int unsigned old_cnt [NCNT];
        int unsigned amt;
        int unsigned s;
        logic [7:0]  set_mask;
        ctrl     = m_cfg[0];
        i_addr   = int'(reg_addr[4:0]);
        snap     = reg_write && reg_addr == 6'd0 && reg_wdata[3];
        set_mask = '0;
        for (int i = 0; i < NCNT; i++) old_cnt[i] = m_cnt[i];
        for (int i = 0; i < NCNT; i++) begin
            amt    = int'(evt_amt[i*8 +: 8]);
            active = evt_inc[i] && !ctrl[2];
            clr    = reg_read && reg_addr[5] && i_addr == i && ctrl[1];
            if (clr) begin
                m_cnt[i]    = active ? amt : 0;
                m_shadow[i] = 0;
            end else begin
                if (active) begin
                    s = old_cnt[i] + amt;
                    if (s > 255) begin
                        set_mask[i] = 1'b1;
                        m_cnt[i] = ctrl[0] ? 255 : s - 256;
                    end else begin
                        m_cnt[i] = s;
                    end
                end
                if (snap) m_shadow[i] = old_cnt[i];
            end
        end
        if (snap) m_snap_seen = 1;
        if (reg_write && reg_addr == 6'h3f) m_sticky = m_sticky & ~reg_wdata[7:0];
        m_sticky = m_sticky | set_mask;
        if (reg_write && !reg_addr[5] && i_addr < NCFG) begin
            m_cfg[i_addr] = reg_wdata[15:0];
            if (i_addr == 0) m_cfg[0][3] = 1'b0;
        end
    endtask

    // One clock cycle with the currently driven inputs, checked against the model.
    task automatic step();
        logic [31:0] exp_rd;
        logic        did_read;
        did_read = reg_read;
        exp_rd   = model_read(reg_addr);
        model_update();
        @(posedge clk);
        #1;
        check("rvalid", 32'(reg_rvalid), 32'(did_read));
        if (did_read) check("rdata", reg_rdata, exp_rd);
        check("irq", 32'(irq), 32'(model_irq()));
        check_cfg_out();
        reg_read  = 1'b0;
        reg_write = 1'b0;
        evt_inc   = '0;
        evt_amt   = '0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        reg_addr  = a;
        reg_wdata = d;
        reg_write = 1'b1;
        step();
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        reg_addr = a;
        reg_read = 1'b1;
        step();
        d = reg_rdata;
    endtask

    task automatic inc(input int i, input logic [7:0] amt);
        evt_inc[i]         = 1'b1;
        evt_amt[i*8 +: 8]  = amt;
        step();
    endtask

    initial begin
        logic [31:0] d;
        logic [5:0]  a;
        int          r;

        rst_n = 1'b0; reg_addr = '0; reg_wdata = '0; reg_write = 1'b0; reg_read = 1'b0;
        evt_inc = '0; evt_amt = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rvalid", 32'(reg_rvalid), 32'd0);
        check("reset_rdata", reg_rdata, 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        check_cfg_out();
        rst_n = 1'b1;

        // Every address reads 0 after reset; rvalid follows each read by one cycle
        for (int i = 0; i < 64; i++) begin
            a = 6'(i);
            rd(a, d);
            check("reset_read", d, 32'd0);
            step();
        end

        // Wrap mode overflow, sticky, irq, W1C
        wr(6'h00, 32'h0100);
        inc(0, 8'd250);
        inc(0, 8'd10);
        rd(6'h20, d);  check("wrap_cnt0", d, 32'd4);
        rd(6'h3f, d);  check("wrap_sticky", d, 32'd1);
        check("wrap_irq", 32'(irq), 32'd1);
        wr(6'h3f, 32'h1);
        check("w1c_irq", 32'(irq), 32'd0);

        // Saturating mode
        wr(6'h00, 32'h0101);
        inc(0, 8'd246);
        inc(0, 8'd10);
        rd(6'h20, d);  check("sat_cnt0", d, 32'd255);
        check("sat_irq", 32'(irq), 32'd1);
        inc(0, 8'd1);
        rd(6'h20, d);  check("sat_hold", d, 32'd255);

        // W1C racing a fresh overflow: set wins
        reg_addr = 6'h3f; reg_wdata = 32'h1; reg_write = 1'b1;
        evt_inc[0] = 1'b1; evt_amt[7:0] = 8'd1;
        step();
        rd(6'h3f, d);  check("set_beats_w1c", d, 32'd1);
        wr(6'h3f, 32'hff);

        // Clear-on-read with a same-cycle event
        wr(6'h00, 32'h0002);
        inc(2, 8'd7);
        reg_addr = 6'h22; reg_read = 1'b1; evt_inc[2] = 1'b1; evt_amt[23:16] = 8'd3;
        step();
        check("cor_first", reg_rdata, 32'd7);
        rd(6'h22, d);  check("cor_second", d, 32'd3);

        // Snapshot
        wr(6'h00, 32'h0000);
        inc(1, 8'd100);
        wr(6'h00, 32'h0008);
        for (int i = 0; i < 5; i++) inc(1, 8'd1);
        rd(6'h21, d);  check("snap_first", d, 32'd100);
        wr(6'h00, 32'h0008);
        rd(6'h21, d);  check("snap_second", d, 32'd105);
        rd(6'h00, d);  check("ctrl_snap_reads0", d, 32'd0);

        // Read/write collision and out-of-range config write
        reg_addr = 6'h05; reg_wdata = 32'h1234; reg_write = 1'b1; reg_read = 1'b1;
        step();
        check("collide_old", reg_rdata, 32'd0);
        rd(6'h05, d);  check("collide_new", d, 32'h1234);
        wr(6'h14, 32'hbeef);
        rd(6'h14, d);  check("cfg_oob", d, 32'd0);

        // Freeze
        wr(6'h00, 32'h0004);
        for (int i = 0; i < 10; i++) begin
            evt_inc = '1;
            evt_amt = {$urandom, $urandom};
            step();
        end
        wr(6'h00, 32'h000c);
        rd(6'h20, d);  check("freeze_cnt0", d, 32'd255);
        rd(6'h21, d);  check("freeze_cnt1", d, 32'd105);
        rd(6'h22, d);  check("freeze_cnt2", d, 32'd0);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            evt_inc = 8'($urandom);
            for (int i = 0; i < NCNT; i++)
                evt_amt[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
            r = int'($urandom_range(0, 9));
            case ($urandom_range(0, 3))
                0:       a = 6'h3f;
                1:       a = 6'($urandom);
                default: a = 6'h20 + 6'($urandom_range(0, 7));
            endcase
            if (r < 4) begin
                reg_read = 1'b1;
                reg_addr = a;
            end
            if (r >= 3 && r < 6) begin
                reg_write = 1'b1;
                reg_wdata = $urandom;
                if (r != 3) begin
                    case ($urandom_range(0, 2))
                        0:       reg_addr = 6'h00;
                        1:       reg_addr = 6'h3f;
                        default: reg_addr = 6'($urandom);
                    endcase
                end
            end
            step();
        end

        // Asynchronous reset with a read response pending
        wr(6'h00, 32'h0000);
        reg_addr = 6'h21; reg_read = 1'b1;
        @(posedge clk);
        #1;
        reg_read = 1'b0;
        check("pre_reset_rvalid", 32'(reg_rvalid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midreset_rvalid", 32'(reg_rvalid), 32'd0);
        check("midreset_rdata", reg_rdata, 32'd0);
        check("midreset_irq", 32'(irq), 32'd0);
        check_cfg_out();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NCNT; i++) begin
            a = 6'h20 + 6'(i);
            rd(a, d);
            check("post_reset_cnt", d, 32'd0);
        end
        rd(6'h3f, d);  check("post_reset_sticky", d, 32'd0);
        rd(6'h00, d);  check("post_reset_ctrl", d, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
